// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage of the RISC-V core.
//
// Owns the PC and drives a request/ready handshake to instruction memory.
// The fetched word is registered and handed to decode (control / alu_control).
// A word that decode has not accepted is held stable while stall is asserted.
// A taken branch redirects the PC.
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   imem_req       fetch request to instruction memory (combinational)
//   imem_addr      fetch address, always equal to pc (combinational)
//   imem_ready     memory accepts request and returns imem_rdata this cycle
//   imem_rdata     fetched word, meaningful only when imem_req && imem_ready
//   stall          downstream cannot accept a new instruction
//   branch_taken   one-cycle redirect request, highest priority
//   branch_target  redirect address, low two bits ignored
//   instruction    registered instruction word (NOP_INSN when nothing valid)
//   pc_out         PC of instruction
//   inst_valid     instruction/pc_out hold a live instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] instruction_next, pc_out_next;
  logic        inst_valid_next;
  logic        hold_req;
  logic [31:0] redirect_pc;

  // A live instruction that decode refuses to take blocks any new fetch.
  assign hold_req    = inst_valid && stall;
  assign redirect_pc = branch_target & ~32'd3;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= NOP_INSN;
      pc_out      <= 32'h0000_0000;
      inst_valid  <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instruction <= instruction_next;
      pc_out      <= pc_out_next;
      inst_valid  <= inst_valid_next;
    end
  end

  // Next-state and next-datapath logic. Redirect beats capture and stall.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    instruction_next = instruction;
    pc_out_next      = pc_out;
    inst_valid_next  = inst_valid;

    case (state)
      IDLE: begin
        // In IDLE a redirect only moves the PC; nothing is in flight to kill.
        state_next = REQ;
        if (branch_taken) begin
          pc_next = redirect_pc;
        end
      end

      REQ: begin
        if (branch_taken) begin
          // Any word returned this cycle belongs to the wrong path.
          pc_next          = redirect_pc;
          inst_valid_next  = 1'b0;
          instruction_next = NOP_INSN;
        end else if (hold_req) begin
          state_next = HOLD;
        end else if (imem_ready) begin
          instruction_next = imem_rdata;
          pc_out_next      = pc;
          inst_valid_next  = 1'b1;
          pc_next          = pc + 32'd4;
        end else if (inst_valid) begin
          // Decode took the word and nothing new arrived.
          inst_valid_next  = 1'b0;
          instruction_next = NOP_INSN;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          state_next       = REQ;
          pc_next          = redirect_pc;
          inst_valid_next  = 1'b0;
          instruction_next = NOP_INSN;
        end else if (!stall) begin
          // The held word is consumed on this edge.
          state_next       = REQ;
          inst_valid_next  = 1'b0;
          instruction_next = NOP_INSN;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request outputs. The request drops in the same cycle that a stall blocks it.
  always_comb begin
    imem_req  = (state == REQ) && !hold_req;
    imem_addr = pc;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage.
//
// Directed cycles drive the memory and downstream inputs. When a cycle is
// expected to capture a word, the word and its PC are pushed into a queue.
// A separate monitor acts as the decode stage. It pops the queue and compares
// each time decode consumes an instruction (inst_valid && !stall).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        inst_valid;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge.
  // Then return at the following falling edge, where outputs are stable.
  task automatic applyStimulus(input logic ready, input logic [31:0] rdata,
                               input logic stl, input logic br,
                               input logic [31:0] tgt);
    @(posedge clk);
    #1;
    imem_ready    = ready;
    imem_rdata    = rdata;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    @(negedge clk);
  endtask

  task automatic expectFetch(input logic [31:0] insn, input logic [31:0] pc);
    exp_q.push_back({insn, pc});
  endtask

  // Decode-side monitor: an instruction is consumed when valid and not stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid && !stall) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_insn: got %h at pc %h, expected none",
                   instruction, pc_out);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_insn", instruction, e.insn);
          checkOutput("sb_pc_out", pc_out, e.pc);
        end
      end
    end
  end

  // Bound the run so a stuck design still produces a verdict.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_insn", instruction, 32'h0000_0013);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_pc_out", pc_out, 32'h0);

    // Release: IDLE for one cycle, request on the second edge
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_req", 32'(imem_req), 32'd0);

    // Straight-line fetch with zero wait states
    applyStimulus(1'b1, 32'h0051_2003, 1'b0, 1'b0, 32'h0);
    checkOutput("first_req", 32'(imem_req), 32'd1);
    checkOutput("addr0", imem_addr, 32'h0);
    expectFetch(32'h0051_2003, 32'h0);

    applyStimulus(1'b1, 32'h0001_22A3, 1'b0, 1'b0, 32'h0);
    checkOutput("addr4", imem_addr, 32'h4);
    expectFetch(32'h0001_22A3, 32'h4);

    // Three wait states at address 8
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("ws_addr_a", imem_addr, 32'h8);
    checkOutput("ws_req", 32'(imem_req), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("ws_addr_b", imem_addr, 32'h8);
    checkOutput("ws_valid", 32'(inst_valid), 32'd0);
    checkOutput("ws_nop", instruction, 32'h0000_0013);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("ws_addr_c", imem_addr, 32'h8);

    applyStimulus(1'b1, 32'h0010_4263, 1'b0, 1'b0, 32'h0);
    checkOutput("ws_addr_d", imem_addr, 32'h8);
    expectFetch(32'h0010_4263, 32'h8);

    applyStimulus(1'b1, 32'h0020_8033, 1'b0, 1'b0, 32'h0);
    checkOutput("addrC", imem_addr, 32'hC);
    checkOutput("valid_after_ws", 32'(inst_valid), 32'd1);
    expectFetch(32'h0020_8033, 32'hC);

    applyStimulus(1'b1, 32'h41FF_8FB3, 1'b0, 1'b0, 32'h0);
    checkOutput("addr10", imem_addr, 32'h10);
    expectFetch(32'h41FF_8FB3, 32'h10);

    // Stall for four cycles: the first cycle in REQ, then three cycles in HOLD
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
      checkOutput("stall_req", 32'(imem_req), 32'd0);
      checkOutput("stall_insn", instruction, 32'h41FF_8FB3);
      checkOutput("stall_pc_out", pc_out, 32'h10);
      checkOutput("stall_valid", 32'(inst_valid), 32'd1);
      checkOutput("stall_addr", imem_addr, 32'h14);
    end

    // Release in HOLD: still no request this cycle
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    checkOutput("unhold_req", 32'(imem_req), 32'd0);

    applyStimulus(1'b1, 32'h00B5_0533, 1'b0, 1'b0, 32'h0);
    checkOutput("post_stall_req", 32'(imem_req), 32'd1);
    checkOutput("post_stall_addr", imem_addr, 32'h14);
    expectFetch(32'h00B5_0533, 32'h14);

    // Redirect colliding with a ready memory: returned word discarded
    applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1, 32'h0000_0103);
    checkOutput("br_insn_before", instruction, 32'h00B5_0533);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("br_valid", 32'(inst_valid), 32'd0);
    checkOutput("br_nop", instruction, 32'h0000_0013);
    checkOutput("br_pc_out", pc_out, 32'h14);
    checkOutput("br_addr", imem_addr, 32'h100);

    // Redirect to the top of memory and wrap past it
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checkOutput("pre_wrap_addr", imem_addr, 32'h100);
    applyStimulus(1'b1, 32'h00A0_0093, 1'b0, 1'b0, 32'h0);
    checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
    expectFetch(32'h00A0_0093, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 32'h00C0_0113, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    expectFetch(32'h00C0_0113, 32'h0);
    applyStimulus(1'b1, 32'h4020_8033, 1'b0, 1'b0, 32'h0);
    checkOutput("after_wrap_addr", imem_addr, 32'h4);
    expectFetch(32'h4020_8033, 32'h4);

    // Asynchronous reset dropped mid-request, between clock edges
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_req", 32'(imem_req), 32'd1);
    checkOutput("mid_addr", imem_addr, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_req", 32'(imem_req), 32'd0);
    checkOutput("arst_valid", 32'(inst_valid), 32'd0);
    checkOutput("arst_insn", instruction, 32'h0000_0013);
    checkOutput("arst_pc_out", pc_out, 32'h0);
    checkOutput("arst_addr", imem_addr, 32'h0);

    // Memory ready while reset is held: nothing is captured
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_hold_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_hold_insn", instruction, 32'h0000_0013);

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
